omok_board_engine: RTL and testbench

//  Parametrised board engine for the Gomoku game. Owns cursor, stone/colour maps, turn, an undo

---
 rtl/omok_pkg.sv | 35 +++
 rtl/omok_board_engine_if.sv | 13 +
 rtl/omok_undo_stack.sv | 45 ++++
 rtl/omok_board_engine.sv | 177 +++++++++++++++++
 tb/tb_omok_board_engine.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/omok_pkg.sv
// rtl/omok_pkg.sv - shared types, winner codes, FSM states and direction table for the omok board engine
package omok_pkg;

  localparam int DEF_MAP_N   = 10;
  localparam int DEF_WIN_LEN = 5;

  typedef enum logic {
    CELL_BLACK = 1'b0,
    CELL_WHITE = 1'b1
  } cell_colour_t;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_BLACK = 2'b01;
  localparam logic [1:0] W_WHITE = 2'b10;
  localparam logic [1:0] W_DRAW  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Direction 0 = horizontal, 1 = vertical, 2 = diagonal, 3 = anti-diagonal ("forward" side).
  function automatic int dir_drow(input logic [1:0] d);
    return (d == 2'd0) ? 0 : 1;
  endfunction

  function automatic int dir_dcol(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 0;
      2'd2:    return 1;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/omok_board_engine_if.sv
// rtl/omok_board_engine_if.sv - keypad command pulse bundle for the omok board engine
interface omok_board_engine_if;
  logic cmd_up;
  logic cmd_down;
  logic cmd_left;
  logic cmd_right;
  logic cmd_put;
  logic cmd_undo;
  logic cmd_new;

  modport master (output cmd_up, cmd_down, cmd_left, cmd_right, cmd_put, cmd_undo, cmd_new);
  modport slave  (input  cmd_up, cmd_down, cmd_left, cmd_right, cmd_put, cmd_undo, cmd_new);
endinterface

// File: rtl/omok_undo_stack.sv
// rtl/omok_undo_stack.sv - circular LIFO of placed cell indices; oldest entry is overwritten when full
module omok_undo_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign pop_data = mem[ptr - PTR_ONE];

  // Entry storage; the pointer wraps so a push when full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[ptr] <= push_data;
  end

  // Top-of-stack pointer and saturating valid-entry count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (clr) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/omok_board_engine.sv
// rtl/omok_board_engine.sv - cursor, stone maps, turn, undo history and sequential N-in-a-row checker
module omok_board_engine
  import omok_pkg::*;
#(
  parameter int MAP_N      = DEF_MAP_N,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int UNDO_DEPTH = 16,
  localparam int CELLS  = MAP_N * MAP_N,
  localparam int POS_W  = $clog2(CELLS),
  localparam int UCNT_W = $clog2(UNDO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  omok_board_engine_if.slave  cmd,
  output logic [POS_W-1:0]    cursor_pos,
  output logic [CELLS-1:0]    board_state,
  output logic [CELLS-1:0]    turn_map,
  output logic                cur_player,
  output logic                busy,
  output logic [1:0]          winner,
  output logic [UCNT_W-1:0]   undo_cnt
);
  localparam int RC_W = $clog2(MAP_N);
  localparam int CW   = RC_W + 2;               // signed walk coordinate, room for off-board excursions
  localparam int SW   = $clog2(WIN_LEN) + 1;
  localparam int LW   = $clog2(2 * WIN_LEN) + 1;

  logic [RC_W-1:0]        cur_row, cur_col, plc_row, plc_col;
  cell_colour_t           plc_colour;
  logic [1:0]             state, dir;
  logic                   side, alive, won;
  logic [SW-1:0]          step;
  logic [LW-1:0]          line_cnt, cnt_next;
  logic signed [CW-1:0]   walk_r, walk_c, probe_r, probe_c;
  logic [POS_W-1:0]       probe_idx, pop_pos;
  logic                   on_board, hit, idle;
  logic                   do_undo, do_put, mv_up, mv_down, mv_left, mv_right;
  int                     pr_i, pc_i;

  assign idle = (state == ST_IDLE);
  assign busy = !idle;

  // Cursor index and one-hot command priority: new > undo > put > up > down > left > right.
  always_comb begin
    cursor_pos = POS_W'(int'(cur_row) * MAP_N + int'(cur_col));
    do_undo  = idle && !cmd.cmd_new && cmd.cmd_undo && (undo_cnt != '0);
    do_put   = idle && !cmd.cmd_new && !cmd.cmd_undo && cmd.cmd_put
               && (winner == W_NONE) && !board_state[cursor_pos];
    mv_up    = idle && !cmd.cmd_new && !cmd.cmd_undo && !cmd.cmd_put && cmd.cmd_up;
    mv_down  = idle && !cmd.cmd_new && !cmd.cmd_undo && !cmd.cmd_put && !cmd.cmd_up && cmd.cmd_down;
    mv_left  = idle && !cmd.cmd_new && !cmd.cmd_undo && !cmd.cmd_put && !cmd.cmd_up && !cmd.cmd_down
               && cmd.cmd_left;
    mv_right = idle && !cmd.cmd_new && !cmd.cmd_undo && !cmd.cmd_put && !cmd.cmd_up && !cmd.cmd_down
               && !cmd.cmd_left && cmd.cmd_right;
  end

  // Next probed cell along the current direction/side; bounds come from row/col, never index wrap.
  always_comb begin
    pr_i      = int'(walk_r) + (side ? -dir_drow(dir) : dir_drow(dir));
    pc_i      = int'(walk_c) + (side ? -dir_dcol(dir) : dir_dcol(dir));
    probe_r   = CW'(pr_i);
    probe_c   = CW'(pc_i);
    on_board  = (pr_i >= 0) && (pr_i < MAP_N) && (pc_i >= 0) && (pc_i < MAP_N);
    probe_idx = on_board ? POS_W'(pr_i * MAP_N + pc_i) : '0;
    hit       = alive && on_board && board_state[probe_idx] && (turn_map[probe_idx] == plc_colour);
    cnt_next  = line_cnt + LW'(hit);
  end

  // Cursor movement, saturating at the board edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || cmd.cmd_new) begin
      cur_row <= RC_W'(MAP_N / 2 - 1);
      cur_col <= RC_W'(MAP_N / 2 - 1);
    end else if (mv_up && cur_row != '0) begin
      cur_row <= cur_row - RC_W'(1);
    end else if (mv_down && cur_row != RC_W'(MAP_N - 1)) begin
      cur_row <= cur_row + RC_W'(1);
    end else if (mv_left && cur_col != '0) begin
      cur_col <= cur_col - RC_W'(1);
    end else if (mv_right && cur_col != RC_W'(MAP_N - 1)) begin
      cur_col <= cur_col + RC_W'(1);
    end
  end

  // Stone maps, side to move and game result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || cmd.cmd_new) begin
      board_state <= '0;
      turn_map    <= '0;
      cur_player  <= 1'b0;
      winner      <= W_NONE;
    end else if (do_undo) begin
      board_state[pop_pos] <= 1'b0;
      turn_map[pop_pos]    <= 1'b0;
      cur_player           <= ~cur_player;
      winner               <= W_NONE;
    end else if (do_put) begin
      board_state[cursor_pos] <= 1'b1;
      turn_map[cursor_pos]    <= cur_player;
      cur_player              <= ~cur_player;
    end else if (state == ST_DONE) begin
      if (won)               winner <= (plc_colour == CELL_WHITE) ? W_WHITE : W_BLACK;
      else if (&board_state) winner <= W_DRAW;
      else                   winner <= W_NONE;
    end
  end

  // Win-check walker: 4 directions x 2 sides x (WIN_LEN-1) steps, then one DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || cmd.cmd_new) begin
      state      <= ST_IDLE;
      dir        <= '0;
      side       <= 1'b0;
      step       <= SW'(1);
      alive      <= 1'b0;
      won        <= 1'b0;
      line_cnt   <= '0;
      walk_r     <= '0;
      walk_c     <= '0;
      plc_row    <= '0;
      plc_col    <= '0;
      plc_colour <= CELL_BLACK;
    end else if (do_put) begin
      state      <= ST_CHECK;
      dir        <= '0;
      side       <= 1'b0;
      step       <= SW'(1);
      alive      <= 1'b1;
      won        <= 1'b0;
      line_cnt   <= '0;
      walk_r     <= $signed({2'b00, cur_row});
      walk_c     <= $signed({2'b00, cur_col});
      plc_row    <= cur_row;
      plc_col    <= cur_col;
      plc_colour <= cell_colour_t'(cur_player);
    end else if (state == ST_CHECK) begin
      if (step == SW'(WIN_LEN - 1)) begin
        step   <= SW'(1);
        alive  <= 1'b1;
        walk_r <= $signed({2'b00, plc_row});
        walk_c <= $signed({2'b00, plc_col});
        if (!side) begin
          side     <= 1'b1;
          line_cnt <= cnt_next;
        end else begin
          side     <= 1'b0;
          line_cnt <= '0;
          if (int'(cnt_next) + 1 >= WIN_LEN) won <= 1'b1;
          if (dir == 2'd3) state <= ST_DONE;
          else             dir   <= dir + 2'd1;
        end
      end else begin
        step     <= step + SW'(1);
        walk_r   <= probe_r;
        walk_c   <= probe_c;
        alive    <= hit;
        line_cnt <= cnt_next;
      end
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end

  omok_undo_stack #(
    .DEPTH (UNDO_DEPTH),
    .WIDTH (POS_W)
  ) u_undo (
    .clk       (clk),
    .rst       (rst),
    .clr       (cmd.cmd_new),
    .push      (do_put),
    .pop       (do_undo),
    .push_data (cursor_pos),
    .pop_data  (pop_pos),
    .count     (undo_cnt)
  );
endmodule

// File: tb/tb_omok_board_engine.sv
// tb/tb_omok_board_engine.sv - randomized and directed self-checking bench with a game-rule reference model
module tb_omok_board_engine;
  localparam int N = 10;
  localparam int W = 5;
  localparam int D = 16;
  localparam int BUSY_LEN = 8 * (W - 1) + 1;

  localparam logic [6:0] C_UP = 7'h01, C_DOWN = 7'h02, C_LEFT = 7'h04, C_RIGHT = 7'h08;
  localparam logic [6:0] C_PUT = 7'h10, C_UNDO = 7'h20, C_NEW = 7'h40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] cmd_v  = '0;
  logic [6:0] cmd3_v = '0;

  omok_board_engine_if cif ();
  omok_board_engine_if cif3 ();
  assign {cif.cmd_new, cif.cmd_undo, cif.cmd_put, cif.cmd_right, cif.cmd_left, cif.cmd_down, cif.cmd_up} = cmd_v;
  assign {cif3.cmd_new, cif3.cmd_undo, cif3.cmd_put, cif3.cmd_right, cif3.cmd_left, cif3.cmd_down, cif3.cmd_up} = cmd3_v;

  logic [6:0]  cur_pos;
  logic [99:0] bs, tm;
  logic        cp, bsy;
  logic [1:0]  win;
  logic [4:0]  ucnt;

  logic [3:0]  cur_pos3;
  logic [8:0]  bs3, tm3;
  logic        cp3, bsy3;
  logic [1:0]  win3;
  logic [2:0]  ucnt3;

  omok_board_engine #(.MAP_N(N), .WIN_LEN(W), .UNDO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd(cif),
    .cursor_pos(cur_pos), .board_state(bs), .turn_map(tm), .cur_player(cp),
    .busy(bsy), .winner(win), .undo_cnt(ucnt)
  );

  omok_board_engine #(.MAP_N(3), .WIN_LEN(3), .UNDO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .cmd(cif3),
    .cursor_pos(cur_pos3), .board_state(bs3), .turn_map(tm3), .cur_player(cp3),
    .busy(bsy3), .winner(win3), .undo_cnt(ucnt3)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game state in plain arrays, win decided by scanning lines around the new stone.
  int          m_r, m_c, m_busy;
  logic        m_player;
  logic [1:0]  m_win, m_pend;
  logic [99:0] m_bs, m_tm;
  int          hist[$];

  task automatic model_reset();
    m_r = N / 2 - 1; m_c = N / 2 - 1; m_busy = 0;
    m_player = 1'b0; m_win = 2'b00; m_pend = 2'b00;
    m_bs = '0; m_tm = '0;
    hist.delete();
  endtask

  function automatic bit line_win(input int r, input int c, input logic colr);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n;
      n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        for (int k = 1; k < W; k++) begin
          int rr, cc;
          rr = r + s * k * dr[d];
          cc = c + s * k * dc[d];
          if (rr < 0 || rr >= N || cc < 0 || cc >= N) break;
          if (!m_bs[rr * N + cc] || m_tm[rr * N + cc] != colr) break;
          n++;
        end
      end
      if (n >= W) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input logic [6:0] v);
    int p;
    if (v[6]) begin model_reset(); return; end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_win = m_pend;
      return;
    end
    if (v[5]) begin
      if (hist.size() > 0) begin
        p = hist.pop_back();
        m_bs[p] = 1'b0; m_tm[p] = 1'b0;
        m_player = !m_player; m_win = 2'b00;
      end
    end else if (v[4]) begin
      p = m_r * N + m_c;
      if (m_win == 2'b00 && !m_bs[p]) begin
        m_bs[p] = 1'b1; m_tm[p] = m_player;
        hist.push_back(p);
        if (hist.size() > D) void'(hist.pop_front());
        if (line_win(m_r, m_c, m_player)) m_pend = m_player ? 2'b10 : 2'b01;
        else if (&m_bs)                   m_pend = 2'b11;
        else                              m_pend = 2'b00;
        m_player = !m_player;
        m_busy = BUSY_LEN;
      end
    end else if (v[0]) begin if (m_r > 0) m_r--; end
    else if (v[1]) begin if (m_r < N - 1) m_r++; end
    else if (v[2]) begin if (m_c > 0) m_c--; end
    else if (v[3]) begin if (m_c < N - 1) m_c++; end
  endtask

  // Every-cycle comparison of all outputs against the model, then advance the model by the
  // command that the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("cursor_pos",  128'(cur_pos), 128'(m_r * N + m_c));
    chk("board_state", 128'(bs), 128'(m_bs));
    chk("turn_map",    128'(tm), 128'(m_tm));
    chk("cur_player",  128'(cp), 128'(m_player));
    chk("busy",        128'(bsy), 128'(m_busy > 0));
    chk("winner",      128'(win), 128'(m_win));
    chk("undo_cnt",    128'(ucnt), 128'(hist.size()));
    if (rst) model_step(cmd_v);
  end

  task automatic drive(input logic [6:0] v);
    cmd_v = v;
    @(posedge clk); #1;
    cmd_v = '0;
  endtask

  task automatic drive3(input logic [6:0] v);
    cmd3_v = v;
    @(posedge clk); #1;
    cmd3_v = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bsy && n < 100) begin drive('0); n++; end
    if (n >= 100) chk("wait_idle_timeout", 128'(bsy), 128'(0));
  endtask

  task automatic move_to(input int p);
    int tr, tc;
    tr = p / N; tc = p % N;
    for (int k = 0; k < 40 && (m_r != tr || m_c != tc); k++) begin
      if (m_r > tr)      drive(C_UP);
      else if (m_r < tr) drive(C_DOWN);
      else if (m_c > tc) drive(C_LEFT);
      else               drive(C_RIGHT);
    end
    chk("move_to", 128'(cur_pos), 128'(p));
  endtask

  task automatic put_at(input int p);
    move_to(p);
    drive(C_PUT);
    wait_idle();
  endtask

  int c3r = 0, c3c = 0;
  task automatic put3(input int r, input int c);
    for (int k = 0; k < 10 && (c3r != r || c3c != c); k++) begin
      if (c3r > r)      begin drive3(C_UP);    c3r--; end
      else if (c3r < r) begin drive3(C_DOWN);  c3r++; end
      else if (c3c > c) begin drive3(C_LEFT);  c3c--; end
      else              begin drive3(C_RIGHT); c3c++; end
    end
    drive3(C_PUT);
    repeat (20) drive3('0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bl[5] = '{40, 41, 42, 43, 44};
    int wh[4] = '{50, 51, 52, 53};
    int ad_b[5] = '{4, 13, 22, 31, 40};
    int ad_w[4] = '{60, 61, 62, 63};
    int ce_b[5] = '{7, 8, 9, 10, 11};
    int ce_w[4] = '{90, 91, 92, 93};
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    chk("reset_cursor", 128'(cur_pos), 128'(44));
    chk("reset_board",  128'(bs), 128'(0));
    chk("reset_winner", 128'(win), 128'(0));
    chk("reset_cursor3", 128'(cur_pos3), 128'(0));

    repeat (6) drive(C_RIGHT);
    chk("right_saturate", 128'(cur_pos), 128'(49));

    for (int i = 0; i < 4; i++) begin put_at(bl[i]); put_at(wh[i]); end
    chk("four_white_no_win", 128'(win), 128'(0));
    move_to(44);
    drive(C_PUT);
    n = 0;
    while (bsy && n < 100) begin n++; drive((n == 3) ? C_PUT : 7'h00); end
    chk("busy_len", 128'(n), 128'(33));
    chk("row_win_black", 128'(win), 128'(1));

    move_to(0);
    drive(C_PUT);
    drive('0);
    chk("put_after_win_cell", 128'(bs[0]), 128'(0));
    chk("put_after_win_player", 128'(cp), 128'(1));
    drive(C_UNDO);
    chk("undo_win_cleared", 128'(win), 128'(0));
    chk("undo_stone_cleared", 128'(bs[44]), 128'(0));

    drive(C_NEW);
    chk("new_board", 128'(bs), 128'(0));
    for (int i = 0; i < 4; i++) begin put_at(ad_b[i]); put_at(ad_w[i]); end
    put_at(ad_b[4]);
    chk("antidiag_win", 128'(win), 128'(1));

    drive(C_NEW);
    for (int i = 0; i < 4; i++) begin put_at(ce_b[i]); put_at(ce_w[i]); end
    put_at(ce_b[4]);
    chk("col_edge_no_wrap", 128'(win), 128'(0));
    chk("col_edge_stone", 128'(bs[11]), 128'(1));

    drive(C_NEW);
    for (int i = 0; i < 17; i++) put_at(i);
    chk("undo_cnt_sat", 128'(ucnt), 128'(16));
    for (int i = 0; i < 16; i++) drive(C_UNDO);
    chk("undo_16_board", 128'(bs), 128'(1));
    chk("undo_16_cnt", 128'(ucnt), 128'(0));
    drive(C_UNDO);
    chk("undo_17_ignored", 128'(bs), 128'(1));

    move_to(55);
    drive(C_PUT);
    repeat (5) drive('0);
    drive(C_NEW | C_PUT);
    chk("abort_board", 128'(bs), 128'(0));
    chk("abort_busy", 128'(bsy), 128'(0));
    chk("abort_cursor", 128'(cur_pos), 128'(44));

    put3(0, 0); put3(0, 1); put3(0, 2); put3(1, 1); put3(1, 0);
    put3(1, 2); put3(2, 1); put3(2, 0); put3(2, 2);
    chk("draw3_winner", 128'(win3), 128'(3));
    chk("draw3_board", 128'(bs3), 128'(9'h1FF));
    chk("draw3_turn", 128'(tm3), 128'(9'h072));

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [6:0] v;
      r = $urandom_range(0, 199);
      if (r == 0)       v = C_NEW;
      else if (r < 8)   v = C_UNDO;
      else if (r < 60)  v = C_PUT;
      else if (r < 180) v = 7'(1 << $urandom_range(0, 3));
      else              v = 7'($urandom_range(0, 63));
      drive(v);
    end
    repeat (40) drive('0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
